// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_queue
// Function : Instruction-fetch front end. Owns the program counter, issues
//            requests to a synchronous program memory and buffers returned
//            instructions (tagged with their PC) in a DEPTH-entry queue that
//            decode drains through a valid/ready handshake. Supports jump
//            redirect with flush, halt freeze and decode back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       halt_sys,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  fetch_pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];

  logic               deq;
  logic               enq;
  logic [CNT_W:0]     credit_sum;

  // Handshake, credit check and request decision
  always_comb begin
    out_valid  = (count != '0) & ~halt_sys;
    deq        = out_valid & out_ready;
    // An inflight response that lands during a redirect belongs to the old path
    enq        = inflight & ~redirect;
    // Slots already promised: queued entries plus the response on its way,
    // minus the one leaving this cycle. Never underflows since deq needs count>0.
    credit_sum = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(deq);
    // Gating with rst keeps the request low while reset is held
    imem_req   = rst & ~halt_sys & ~redirect & (credit_sum < (CNT_W+1)'(DEPTH));
  end

  assign imem_addr = fetch_pc;
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  assign occupancy = count;

  // PC, inflight tracking and queue pointer/count control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      // A request is never made in a redirect cycle, so this also kills
      // the old-path response tracking
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
      end

      if (redirect) begin
        fetch_pc <= redirect_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (imem_req) begin
          fetch_pc <= fetch_pc + STEP;
        end
        if (enq) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (deq) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // Queue storage: capture the response with its PC at the write pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (enq) begin
      instr_q[wr_ptr] <= imem_data;
      pc_q[wr_ptr]    <= inflight_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_queue
// Function : Directed self-checking bench for fetch_prefetch_queue. Memory
//            word at address a is a + 0x1000 so PC and instruction differ.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_sys;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [2:0]  occupancy;

  // Second instance: 8-bit addresses starting near the top to show wrap
  logic        imem_req2;
  logic [7:0]  imem_addr2;
  logic [15:0] imem_data2;
  logic        redirect2;
  logic [7:0]  redirect_pc2;
  logic        halt2;
  logic        out_valid2;
  logic        out_ready2;
  logic [15:0] out_instr2;
  logic [7:0]  out_pc2;
  logic [2:0]  occupancy2;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  fetch_prefetch_queue #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_sys(halt_sys), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
  );

  fetch_prefetch_queue #(
    .ADDR_W(8), .INSTR_W(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(8'hFC)
  ) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .halt_sys(halt2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_pc(out_pc2), .occupancy(occupancy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous program memories: data valid the cycle after the request
  always @(posedge clk) begin
    if (imem_req)  imem_data  <= imem_addr + 16'h1000;
    if (imem_req2) imem_data2 <= {8'h00, imem_addr2} + 16'h1000;
    if (imem_req)  req_cnt    <= req_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_pc;
  logic [7:0]  exp2;
  logic [15:0] hold_addr;
  int          req_base;

  // Check the head for n consecutive cycles, consuming one each cycle
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc", 32'(out_pc), 32'(exp_pc));
      chk("stream_instr", 32'(out_instr), 32'(exp_pc + 16'h1000));
      tick();
      exp_pc = exp_pc + 16'd2;
    end
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_sys = 1'b0; out_ready = 1'b1;
    redirect2 = 1'b0; redirect_pc2 = '0; halt2 = 1'b0; out_ready2 = 1'b1;
    imem_data = '0; imem_data2 = '0;

    // Reset state
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_addr2", 32'(imem_addr2), 32'h00FC);

    // Release: first request immediately at RESET_PC
    rst = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
    tick();
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    chk("lat_n1_addr", 32'(imem_addr), 32'd2);
    tick();

    // Full-rate stream; wrap instance checked alongside
    exp_pc = 16'h0000;
    exp2   = 8'hFC;
    for (int i = 0; i < 6; i++) begin
      chk("s1_valid", 32'(out_valid), 32'd1);
      chk("s1_pc", 32'(out_pc), 32'(exp_pc));
      chk("s1_instr", 32'(out_instr), 32'(exp_pc + 16'h1000));
      if (i < 4) begin
        chk("wrap_valid", 32'(out_valid2), 32'd1);
        chk("wrap_pc", 32'(out_pc2), 32'(exp2));
      end
      tick();
      exp_pc = exp_pc + 16'd2;
      exp2   = exp2 + 8'd2;
    end

    // Halt for 5 cycles: head is exp_pc, next fetch address is exp_pc+4
    hold_addr = exp_pc + 16'd4;
    halt_sys = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("halt_valid", 32'(out_valid), 32'd0);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_addr", 32'(imem_addr), 32'(hold_addr));
      tick();
    end
    halt_sys = 1'b0;
    #1;
    stream(4);

    // Reset with two queued entries and a fetch inflight
    out_ready = 1'b0;
    tick();
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", 32'(out_pc), 32'd0);
    chk("arst_instr", 32'(out_instr), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    tick();

    // Back-pressure from reset: exactly 4 requests then stop
    req_base = req_cnt;
    rst = 1'b1;
    #1;
    chk("bp_first_addr", 32'(imem_addr), 32'd0);
    for (int k = 0; k < 8; k++) tick();
    chk("bp_req_count", 32'(req_cnt - req_base), 32'd4);
    chk("bp_req_low", 32'(imem_req), 32'd0);
    chk("bp_occ", 32'(occupancy), 32'd4);
    chk("bp_addr", 32'(imem_addr), 32'd8);

    // Release back-pressure: in order, none lost
    out_ready = 1'b1;
    exp_pc = 16'h0000;
    #1;
    stream(6);

    // Redirect with 3 queued and one inflight; head this cycle is consumed
    chk("pre_redir_occ", 32'(occupancy), 32'd3);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    chk("redir_deq_valid", 32'(out_valid), 32'd1);
    chk("redir_deq_pc", 32'(out_pc), 32'(exp_pc));
    chk("redir_no_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_occ", 32'(occupancy), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'h0040);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_valid_n1", 32'(out_valid), 32'd0);
    tick();
    chk("redir_valid_n2", 32'(out_valid), 32'd0);
    tick();
    exp_pc = 16'h0040;
    stream(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction-fetch front end: owns the program counter, issues fetch requests to a synchronous program memory and buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue. Decode consumes them through a valid/ready handshake. It replaces the fixed single-register PC-and-fetch path at the head of the pipeline. It adds jump redirect with queue flush, halt freeze and back-pressure from the hazard stall.

## Interface
- ADDR_W, 16, PC / memory address width
- INSTR_W, 16, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- PC_STEP, 2, PC increment per sequential fetch
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address (= fetch PC register)
- imem_data  in  INSTR_W  memory data, valid the cycle after imem_req
- redirect  in  1  jump taken; flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  jump target
- halt_sys  in  1  freeze fetch and issue
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts (0 = hazard stall)
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction
- occupancy  out  $clog2(DEPTH+1)  entries held

## Operation
- State: fetch_pc, inflight flag plus inflight PC, circular queue (wr_ptr, rd_ptr, count).
- deq = out_valid & out_ready.
- imem_req = ~halt_sys & ~redirect & (count + inflight - deq < DEPTH).
- On request: inflight <= 1, inflight PC <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP, mod 2^ADDR_W (wraps to 0).
- Inflight response: written to queue at wr_ptr the cycle after request, unless killed. The credit rule guarantees the queue is never written when full.
- out_valid = (count != 0) & ~halt_sys. out_instr and out_pc drive the head slot directly.
- Redirect: in the same cycle, fetch_pc <= redirect_pc, count/pointers cleared and inflight response killed (not written).
  - A deq in the redirect cycle completes; that instruction is the one consumed.
  - Redirect overrides halt_sys.
  - No request in the redirect cycle.
- Halt: no request, out_valid 0, no dequeue, fetch_pc held. An already-inflight response is still captured.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance mod DEPTH.
- redirect_pc used as given; alignment is not checked.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, occupancy 0. Queue storage cleared, inflight 0.
- Reset is asynchronous on assertion, including mid-fetch: any inflight response is discarded.
- First request: first cycle after rst rises (addr RESET_PC).
- Fetch-to-issue latency: request in cycle N, data in N+1, out_valid in N+2.
- Throughput: 1 instruction/cycle with out_ready held 1 and any DEPTH >= 2.
- Redirect in cycle N: request for redirect_pc in N+1; its out_valid in N+3.
- out_ready low: queue fills to DEPTH, then imem_req drops. With DEPTH=4 and out_ready 0 from reset, exactly 4 requests issue, then occupancy stays 4.
- occupancy is registered count.

## Test plan
- Reset release, out_ready=1, memory word at addr a = a: out_valid first high 2 cycles after first request. out_pc/out_instr stream 0, 2, 4, … one per cycle, no gaps.
- out_ready=0 from reset, DEPTH=4: 4 requests (0, 2, 4, 6), then imem_req=0 and occupancy=4. Release out_ready: 0, 2, 4, 6, 8, … in order, none lost or duplicated.
- Redirect to 0x0040 while queue holds 3 entries and a fetch is inflight: the entry handshaken that cycle is consumed. Next cycle occupancy=0 and imem_addr=0x0040. Next delivered out_pc=0x0040, no stale entry appears.
- halt_sys for 5 cycles mid-stream: out_valid 0 and imem_req 0 throughout, fetch_pc held. After release the stream resumes at the next sequential PC with no skip.
- ADDR_W=8, RESET_PC=0xFC: fetched PCs 0xFC, 0xFE, 0x00, 0x02, i.e. wrap-around.
- rst asserted with inflight fetch and 2 queued entries: all outputs return to their reset values immediately. After release, fetch restarts at RESET_PC.
